muldiv_div_unit: RTL
====================

// Module: muldiv_div_unit
// PURPOSE
//  Iterative RV32M divide unit (DIV/DIVU/REM/REMU) next to the single-cycle ALU in EX.
//  Control raises start with operands; the unit computes one quotient bit per cycle.
//  It returns the result with a one-cycle done pulse. EX stalls while busy is high.
//  Division by zero and signed overflow follow the RISC-V spec and take the short path.
// PARAMETERS
//  XLEN   32   operand/result width; the iteration count equals XLEN
// PORTS
//  clk     in   1     clock, rising edge
//  rst     in   1     asynchronous, active-high reset
//  start   in   1     request; accepted only when busy==0
//  op      in   2     00=DIV 01=DIVU 10=REM 11=REMU (funct3[1:0] of 1xx)
//  a       in   XLEN  dividend (rs1), sampled on accept
//  b       in   XLEN  divisor (rs2), sampled on accept
//  busy    out  1     high from the cycle after accept until the cycle done is high
//  done    out  1     one-cycle pulse; result valid in this cycle and held after it
//  result  out  XLEN  quotient or remainder per op; held until the next done
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, internal regs=0.
//  Reset mid-operation aborts the operation. No done is produced for it.
//  FSM states are IDLE, CALC, FIN.
//   IDLE
//    - start=1 latches op/a/b.
//    - b==0 goes to FIN with the special result.
//    - Signed ops with a==0x80000000 and b==0xFFFFFFFF go to FIN with the special result.
//    - Otherwise the FSM loads the magnitudes into the work regs, sets count=XLEN-1, and enters CALC.
//   CALC
//    - Restoring step per cycle: rem={rem,quo[MSB]}; quo<<=1.
//    - If rem>=|b|: rem-=|b| and quo[0]=1.
//    - At count==0 the FSM goes to FIN; otherwise count is decremented.
//   FIN
//    - Applies sign fix-up, drives result, asserts done for 1 cycle, then returns to IDLE.
//  Latency, start-accept to done
//   - Normal operation: XLEN+1 cycles (33 for XLEN=32).
//   - Special cases: 1 cycle.
//  busy rules
//   - busy=1 in CALC and FIN. busy=0 in IDLE.
//   - start while busy is ignored. Operands are not re-sampled.
//   - start may be asserted in the cycle after done. It is accepted, with back-to-back issue.
//  Signed rules
//   - Operate on absolute values.
//   - Negate the quotient if sign(a)^sign(b).
//   - Negate the remainder if sign(a). The remainder takes the sign of the dividend.
//   - Truncation is toward zero.
//  Special results
//   - b==0: DIV/DIVU give all-ones. REM/REMU give a.
//   - Overflow (DIV only, signed): quotient is 0x80000000, remainder is 0.
//  Width: the internal remainder is XLEN+1 bits so the subtract compare cannot overflow.
//  No exceptions are raised. The unit never flags divide-by-zero.
// TESTING
//  1. DIVU a=100,b=7: start 1 cycle -> busy 1, done at +33, result=14.
//  2. REMU a=100,b=7 -> result=2. DIV a=-20,b=3 -> result=0xFFFFFFFA (-6).
//  3. REM a=-20,b=3 -> result=0xFFFFFFFE (-2). REM a=20,b=-3 -> result=2.
//  4. DIV a=5,b=0 -> done at +1, result=0xFFFFFFFF. REMU a=5,b=0 -> result=5.
//  5. DIV a=0x80000000,b=-1 -> done at +1, result=0x80000000. REM of the same operands -> result=0.
//  6. Assert start again mid-CALC with different a/b: it is ignored and the first result is unchanged.
//     Assert rst at cycle 10: busy=0, done=0, result=0, and no done follows.

Source files
------------

// File: rtl/muldiv_div_if.sv
// Request/response bundle between EX control and the iterative divide unit.
// The master issues start/op/operands; the slave returns busy, the done pulse and the result.
interface muldiv_div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved in a single cycle.
module muldiv_div_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_div_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t state, next_state;

    logic            busy, done, accept, last_step;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo, divisor, result;
    logic [CW-1:0]   count;
    logic            is_rem, neg_q, neg_r;

    logic            is_signed, a_neg, b_neg, div_zero, overflow, special;
    logic [XLEN-1:0] abs_a, abs_b, special_val;
    logic [XLEN:0]   shifted, divisor_ext, step_rem;
    logic [XLEN-1:0] step_quo, fixed;
    logic            ge;

    function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
        logic signed [XLEN-1:0] sv;
        sv = v;
        return neg ? -sv : sv;
    endfunction

    // Operand decode: magnitudes and the two single-cycle special cases
    always_comb begin
        is_signed = ~bus.op[0];
        a_neg     = is_signed & bus.a[XLEN-1];
        b_neg     = is_signed & bus.b[XLEN-1];
        abs_a     = negate_if(a_neg, bus.a);
        abs_b     = negate_if(b_neg, bus.b);
        div_zero  = (bus.b == '0);
        overflow  = is_signed && (bus.a == MIN_INT) && (bus.b == '1);
        special   = div_zero | overflow;
        if (div_zero)
            special_val = bus.op[1] ? bus.a : '1;
        else
            special_val = bus.op[1] ? '0 : MIN_INT;
    end

    // Restoring step; the extra remainder bit keeps the compare exact for |b| up to 2^XLEN-1
    always_comb begin
        shifted     = (rem << 1) | {{XLEN{1'b0}}, quo[XLEN-1]};
        divisor_ext = {1'b0, divisor};
        ge          = (shifted >= divisor_ext);
        step_rem    = ge ? (shifted - divisor_ext) : shifted;
        step_quo    = {quo[XLEN-2:0], ge};
        fixed       = is_rem ? negate_if(neg_r, XLEN'(step_rem)) : negate_if(neg_q, step_quo);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = special ? FIN : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == '0) begin
                    last_step  = 1'b1;
                    next_state = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The result register is loaded on entry to FIN so it is stable for the done cycle and after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            count   <= '0;
            result  <= '0;
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            is_rem <= bus.op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (special) begin
                result <= special_val;
            end else begin
                quo     <= abs_a;
                rem     <= '0;
                divisor <= abs_b;
                count   <= CW'(XLEN - 1);
            end
        end else if (state == CALC) begin
            quo   <= step_quo;
            rem   <= step_rem;
            count <= count - 1'b1;
            if (last_step)
                result <= fixed;
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
endmodule
